fp_align_ctrl: RTL and testbench

- Multi-cycle sequencer for the FP adder alignment stage.
- Accepts two operands, orders them by magnitude, and derives effective operation and shift distance.
- Right-shifts the smaller mantissa STEP bits per cycle, accumulating guard/round/sticky, and presents aligned operands to the add/round stage.
- Valid/ready handshakes on both sides.

---
 rtl/fp_align_pkg.sv | 26 ++
 rtl/grs_shift_step.sv | 17 +
 rtl/fp_align_ctrl.sv | 105 ++++++++++
 tb/tb_fp_align_ctrl.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/fp_align_pkg.sv
// fp_align_pkg: shared types and constants for the FP adder alignment stage
package fp_align_pkg;
  localparam int N = 23;
  localparam int EXP = 8;
  localparam int STEP = 4;
  localparam int SHAMT_MAX = N + 3;
  localparam int SW = $clog2(SHAMT_MAX + 1);
  typedef enum logic [1:0] {IDLE, COMPARE, SHIFT, DONE} state_t;
  typedef struct packed {
    logic sign;
    logic [EXP-1:0] exp;
    logic [N-1:0] mant;
  } operand_t;
  typedef struct packed {
    logic g;
    logic r;
    logic s;
  } grs_t;
  // Denormals (and zero) behave as exponent 1 with no hidden bit
  function automatic logic [EXP-1:0] eff_exp(input operand_t o);
    return (o.exp == '0) ? EXP'(1) : o.exp;
  endfunction
  function automatic logic [N:0] full_mant(input operand_t o);
    return {|o.exp, o.mant};
  endfunction
endpackage

// File: rtl/grs_shift_step.sv
// grs_shift_step: one right-shift step of {mant,G,R,S} with sticky merge
module grs_shift_step
  import fp_align_pkg::*;
(
  input  logic [N:0]    mant,
  input  grs_t          grs_in,
  input  logic [SW-1:0] k,
  output logic [N:0]    mant_out,
  output grs_t          grs_out
);
  logic [N+2:0] wide;
  logic [N+2:0] lost_mask;
  assign wide = {mant, grs_in.g, grs_in.r};
  assign lost_mask = ~({(N+3){1'b1}} << k);
  assign {mant_out, grs_out.g, grs_out.r} = wide >> k;
  assign grs_out.s = grs_in.s | (|(wide & lost_mask));
endmodule

// File: rtl/fp_align_ctrl.sv
// fp_align_ctrl: multi-cycle operand ordering and alignment sequencer for the FP adder
module fp_align_ctrl
  import fp_align_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           a_sign,
  input  logic           b_sign,
  input  logic [EXP-1:0] a_exp,
  input  logic [EXP-1:0] b_exp,
  input  logic [N-1:0]   a_mant,
  input  logic [N-1:0]   b_mant,
  input  logic           sub_ctrl,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           big_sign,
  output logic [EXP-1:0] big_exp,
  output logic [N:0]     big_mant,
  output logic [N:0]     small_mant,
  output logic           guard,
  output logic           round,
  output logic           sticky,
  output logic           eff_sub,
  output logic           swapped,
  output logic           busy
);
  state_t state, state_n;
  operand_t a_q, b_q;
  logic sub_q;
  logic [SW-1:0] rem, d, k;
  logic [EXP-1:0] ea, eb, diff;
  logic [N:0] ma, mb, small_nx;
  logic a_lt;
  grs_t grs_q, grs_nx;
  assign in_ready = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy = (state != IDLE);
  assign {guard, round, sticky} = grs_q;
  always_comb begin
    ea = eff_exp(a_q);
    eb = eff_exp(b_q);
    ma = full_mant(a_q);
    mb = full_mant(b_q);
    a_lt = (ea < eb) || ((ea == eb) && (ma < mb));
    diff = a_lt ? eb - ea : ea - eb;
    d = (diff > EXP'(SHAMT_MAX)) ? SW'(SHAMT_MAX) : diff[SW-1:0];
    k = (rem > SW'(STEP)) ? SW'(STEP) : rem;
  end
  always_comb begin
    state_n = state;
    state_n = (state == IDLE && in_valid) ? COMPARE :
              (state == COMPARE) ? ((d == '0) ? DONE : SHIFT) :
              (state == SHIFT && rem == k) ? DONE :
              (state == DONE && out_ready) ? IDLE : state;
  end
  grs_shift_step u_step (
    .mant    (small_mant),
    .grs_in  (grs_q),
    .k       (k),
    .mant_out(small_nx),
    .grs_out (grs_nx)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      sub_q <= 1'b0;
      rem <= '0;
      big_sign <= 1'b0;
      big_exp <= '0;
      big_mant <= '0;
      small_mant <= '0;
      grs_q <= '0;
      eff_sub <= 1'b0;
      swapped <= 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        a_q <= {a_sign, a_exp, a_mant};
        b_q <= {b_sign, b_exp, b_mant};
        sub_q <= sub_ctrl;
      end
      if (state == COMPARE) begin
        swapped <= a_lt;
        big_sign <= a_lt ? (b_q.sign ^ sub_q) : a_q.sign;
        big_exp <= a_lt ? b_q.exp : a_q.exp;
        big_mant <= a_lt ? mb : ma;
        small_mant <= a_lt ? ma : mb;
        grs_q <= '0;
        eff_sub <= a_q.sign ^ b_q.sign ^ sub_q;
        rem <= d;
      end
      if (state == SHIFT) begin
        small_mant <= small_nx;
        grs_q <= grs_nx;
        rem <= rem - k;
      end
    end
  end
endmodule

// File: tb/tb_fp_align_ctrl.sv
// tb_fp_align_ctrl: directed self-checking bench for fp_align_ctrl
module tb_fp_align_ctrl;
  import fp_align_pkg::*;
  logic clk, rst_n, in_valid, in_ready, a_sign, b_sign, sub_ctrl;
  logic [EXP-1:0] a_exp, b_exp, big_exp;
  logic [N-1:0] a_mant, b_mant;
  logic out_valid, out_ready, big_sign, guard, round, sticky, eff_sub, swapped, busy;
  logic [N:0] big_mant, small_mant;
  int n_chk, n_fail;

  fp_align_ctrl dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a_sign(a_sign), .b_sign(b_sign), .a_exp(a_exp), .b_exp(b_exp),
    .a_mant(a_mant), .b_mant(b_mant), .sub_ctrl(sub_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .big_sign(big_sign),
    .big_exp(big_exp), .big_mant(big_mant), .small_mant(small_mant),
    .guard(guard), .round(round), .sticky(sticky), .eff_sub(eff_sub),
    .swapped(swapped), .busy(busy)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_chk++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic as, input int ae, input int am,
                       input logic bs, input int be, input int bm, input logic sc);
    a_sign = as; a_exp = EXP'(ae); a_mant = N'(am);
    b_sign = bs; b_exp = EXP'(be); b_mant = N'(bm);
    sub_ctrl = sc;
  endtask

  task automatic run_op(input string tag, input logic as, input int ae, input int am,
                        input logic bs, input int be, input int bm, input logic sc,
                        input int lat_want);
    int lat;
    drive(as, ae, am, bs, be, bm, sc);
    in_valid = 1;
    tick();
    in_valid = 0;
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_in_ready_busy"}, in_ready, 0);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!out_valid && lat < 40);
    chk({tag, "_latency"}, lat, lat_want);
  endtask

  task automatic check_out(input string tag, input logic bsg, input int bexp, input int bm,
                           input int sm, input logic [2:0] grs, input logic es, input logic sw);
    chk({tag, "_big_sign"}, big_sign, bsg);
    chk({tag, "_big_exp"}, big_exp, bexp);
    chk({tag, "_big_mant"}, big_mant, bm);
    chk({tag, "_small_mant"}, small_mant, sm);
    chk({tag, "_grs"}, {guard, round, sticky}, grs);
    chk({tag, "_eff_sub"}, eff_sub, es);
    chk({tag, "_swapped"}, swapped, sw);
  endtask

  task automatic release_out(input string tag);
    out_ready = 1;
    tick();
    out_ready = 0;
    chk({tag, "_valid_drop"}, out_valid, 0);
    chk({tag, "_idle_ready"}, in_ready, 1);
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    rst_n = 0;
    in_valid = 0;
    out_ready = 0;
    drive(0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_data", {big_mant, small_mant, guard, round, sticky, swapped}, 0);
    rst_n = 1;
    tick();

    run_op("t1", 0, 130, 'h400000, 0, 128, 0, 0, 2);
    check_out("t1", 0, 130, 'hC00000, 'h200000, 3'b000, 0, 0);
    release_out("t1");

    run_op("t2", 0, 150, 0, 0, 127, 'h000001, 0, 7);
    check_out("t2", 0, 150, 'h800000, 'h000001, 3'b001, 0, 0);
    release_out("t2");

    run_op("t3", 0, 127, 'h100000, 0, 127, 'h200000, 1, 1);
    check_out("t3", 1, 127, 'hA00000, 'h900000, 3'b000, 1, 1);
    release_out("t3");

    run_op("t4", 1, 200, 'h7FFFFF, 1, 100, 'h000010, 0, 8);
    check_out("t4", 1, 200, 'hFFFFFF, 0, 3'b001, 0, 0);
    release_out("t4");

    run_op("t4z", 1, 200, 'h7FFFFF, 1, 0, 0, 0, 8);
    check_out("t4z", 1, 200, 'hFFFFFF, 0, 3'b000, 0, 0);
    release_out("t4z");

    run_op("d4", 0, 131, 0, 0, 127, 'h00000F, 0, 2);
    check_out("d4", 0, 131, 'h800000, 'h080000, 3'b111, 0, 0);
    release_out("d4");

    run_op("d5", 0, 132, 0, 0, 127, 'h000010, 0, 3);
    check_out("d5", 0, 132, 'h800000, 'h040000, 3'b100, 0, 0);
    release_out("d5");

    run_op("bp", 0, 130, 'h400000, 0, 128, 0, 0, 2);
    drive(1, 10, 'h123456, 0, 20, 'h654321, 1);
    in_valid = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid_hold", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_data_hold", {big_mant, small_mant, guard, round, sticky, swapped, eff_sub}, {24'hC00000, 24'h200000, 5'b0});
    end
    in_valid = 0;
    release_out("bp");
    tick();
    chk("bp_no_accept", busy, 0);

    drive(0, 150, 0, 0, 127, 'h000001, 0);
    in_valid = 1;
    tick();
    in_valid = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rs_busy_in_shift", busy, 1);
    rst_n = 0;
    tick();
    chk("rs_busy", busy, 0);
    chk("rs_out_valid", out_valid, 0);
    chk("rs_in_ready", in_ready, 1);
    chk("rs_data", {big_exp, big_mant, small_mant, guard, round, sticky, swapped, eff_sub, big_sign}, 0);
    rst_n = 1;
    tick();
    run_op("after_rs", 0, 150, 0, 0, 127, 'h000001, 0, 7);
    check_out("after_rs", 0, 150, 'h800000, 'h000001, 3'b001, 0, 0);
    release_out("after_rs");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
